// File: rtl/riscv_dbg_auth_pkg.sv
// Shared types and constants for the MMU debug-unlock authenticator.
package riscv_dbg_auth_pkg;

    // Fetch privilege encodings as seen on priv_i.
    localparam logic [1:0] PRIV_USER    = 2'd0;
    localparam logic [1:0] PRIV_SUPER   = 2'd1;
    localparam logic [1:0] PRIV_MACHINE = 2'd3;

    // Key the block unlocks with unless overridden at instantiation.
    localparam logic [31:0] DBG_KEY_DEFAULT = 32'hA5C3_0F1E;

    // Fail counter width; MAX_FAIL tops out at 15.
    localparam int FAIL_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACTIVE = 2'd2,
        LOCKED = 2'd3
    } dbg_state_e;

    // Completion response returned to the requester.
    typedef struct packed {
        logic ack;
        logic ok;
    } dbg_rsp_t;

    // Bits needed to hold a count of v (at least 1).
    function automatic int cnt_width(input int v);
        int w;
        w = $clog2(v + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/riscv_dbg_timer.sv
// Loadable down-counter shared by the lockout and session timers.
// zero_o flags an empty counter; last_o flags the final counted cycle so the
// owner can leave its state on the same edge the count reaches zero.
module riscv_dbg_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/riscv_mmu_dbg_auth.sv
// Debug-unlock authenticator feeding the MMU debug override and supervisor
// qualifier. A rising edge on dbg_req_i starts a key check; a match opens a
// debug session, MAX_FAIL consecutive mismatches lock the port for
// LOCKOUT_CYCLES clocks.
// Optional feature: define RISCV_DBG_SESSION_TIMEOUT_EN to end sessions
// automatically after TIMEOUT_CYCLES clocks.
module riscv_mmu_dbg_auth
    import riscv_dbg_auth_pkg::*;
#(
    parameter logic [31:0] DBG_KEY        = DBG_KEY_DEFAULT,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 1024,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dbg_req_i,
    input  logic [31:0] dbg_key_i,
    input  logic        dbg_exit_i,
    input  logic [1:0]  priv_i,
    output logic        dbg_ack_o,
    output logic        dbg_ok_o,
    output logic        dbg_mode_o,
    output logic        supervisor_o,
    output logic        locked_o
);

    // One timer serves both lockout and session timeout (the states are
    // exclusive), so it is sized for the larger of the two loads.
    localparam int TMR_W = cnt_width((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ?
                                     LOCKOUT_CYCLES : TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCKOUT_CYCLES);

    dbg_state_e        state_q, state_d;
    logic              req_q;
    logic [31:0]       key_q;
    logic [FAIL_W-1:0] fail_q, fail_d;
    dbg_rsp_t          rsp_q, rsp_d;
    logic              mode_q, locked_q;
    logic              key_ld;
    logic              tmr_load, tmr_en, tmr_zero, tmr_last;
    logic [TMR_W-1:0]  tmr_val;
    logic              req_rise, key_match, sess_end;

    assign req_rise  = dbg_req_i & ~req_q;
    assign key_match = (key_q == DBG_KEY);

`ifdef RISCV_DBG_SESSION_TIMEOUT_EN
    localparam logic [TMR_W-1:0] SESS_LD = TMR_W'(TIMEOUT_CYCLES);
    assign sess_end = dbg_exit_i | tmr_last;
`else
    assign sess_end = dbg_exit_i;
`endif

    riscv_dbg_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero),
        .last_o     (tmr_last)
    );

    // Next-state, fail counter, response and timer control.
    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        rsp_d    = '0;
        key_ld   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_rise) begin
                    key_ld  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                rsp_d.ack = 1'b1;
                rsp_d.ok  = key_match;
                if (key_match) begin
                    state_d = ACTIVE;
                    fail_d  = '0;
`ifdef RISCV_DBG_SESSION_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = SESS_LD;
`endif
                end else if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
                    state_d  = LOCKED;
                    fail_d   = FAIL_W'(MAX_FAIL);
                    tmr_load = 1'b1;
                    tmr_val  = LOCK_LD;
                end else begin
                    state_d = IDLE;
                    fail_d  = fail_q + 1'b1;
                end
            end
            ACTIVE: begin
`ifdef RISCV_DBG_SESSION_TIMEOUT_EN
                tmr_en = 1'b1;
`endif
                // Session end beats a simultaneous request, which is dropped.
                if (sess_end) begin
                    state_d = IDLE;
                end else if (req_rise) begin
                    rsp_d.ack = 1'b1;
                    rsp_d.ok  = 1'b1;
                end
            end
            LOCKED: begin
                tmr_en = 1'b1;
                // Requests are refused without touching the key or counter.
                if (req_rise) begin
                    rsp_d.ack = 1'b1;
                end
                if (tmr_last || tmr_zero) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge detect, key capture and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            key_q    <= '0;
            fail_q   <= '0;
            rsp_q    <= '0;
            mode_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= dbg_req_i;
            fail_q   <= fail_d;
            rsp_q    <= rsp_d;
            mode_q   <= (state_d == ACTIVE);
            locked_q <= (state_d == LOCKED);
            if (key_ld) begin
                key_q <= dbg_key_i;
            end
        end
    end

    assign dbg_ack_o    = rsp_q.ack;
    assign dbg_ok_o     = rsp_q.ok;
    assign dbg_mode_o   = mode_q;
    assign locked_o     = locked_q;
    assign supervisor_o = (priv_i == PRIV_SUPER) | mode_q;

endmodule

// File: tb/tb_riscv_mmu_dbg_auth.sv
// Bench for riscv_mmu_dbg_auth: a timestamp-based reference model checks
// every cycle, with directed sequences and literal expectations up front
// followed by randomized traffic including resets.
module tb_riscv_mmu_dbg_auth;

    localparam logic [31:0] KEY  = 32'hA5C3_0F1E;
    localparam int          MAXF = 3;
    localparam int          LOCK = 1024;
    localparam int          TOUT = 8;
    localparam int          INF  = 32'h7fff_ffff;
`ifdef RISCV_DBG_SESSION_TIMEOUT_EN
    localparam bit SESS_TO = 1'b1;
`else
    localparam bit SESS_TO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        exit_p = 1'b0;
    logic [31:0] key = '0;
    logic [1:0]  priv = 2'd0;
    logic        ack, ok, mode, sup, locked;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int lk_cnt = 0;
    int md_cnt = 0;

    always #5 clk = ~clk;

    riscv_mmu_dbg_auth #(
        .DBG_KEY        (KEY),
        .MAX_FAIL       (MAXF),
        .LOCKOUT_CYCLES (LOCK),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .dbg_req_i    (req),
        .dbg_key_i    (key),
        .dbg_exit_i   (exit_p),
        .priv_i       (priv),
        .dbg_ack_o    (ack),
        .dbg_ok_o     (ok),
        .dbg_mode_o   (mode),
        .supervisor_o (sup),
        .locked_o     (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Cycle n is the interval ending at the (n+1)th negedge. The model keeps
    // session/lockout windows as [start,end) cycle ranges and a list of
    // cycles on which an ack is due.
    int cyc = 0;
    int m_start = INF, m_end = INF, l_start = INF, l_end = INF, chk = -1;
    int fails = 0;
    bit prev_req = 1'b0;
    int ack_at[$];
    bit ack_val[$];

    always @(negedge clk) begin
        bit e_ack, e_ok, e_mode, e_lock, rise;
        cyc++;
        e_ack = 1'b0;
        e_ok  = 1'b0;
        if (!rst_n) begin
            ack_at.delete();
            ack_val.delete();
            m_start = INF; m_end = INF; l_start = INF; l_end = INF;
            chk = -1; fails = 0; prev_req = 1'b0;
        end else if (ack_at.size() != 0 && ack_at[0] == cyc) begin
            e_ack = 1'b1;
            e_ok  = ack_val[0];
            void'(ack_at.pop_front());
            void'(ack_val.pop_front());
        end
        e_mode = (cyc >= m_start) && (cyc < m_end);
        e_lock = (cyc >= l_start) && (cyc < l_end);

        check("m_ack", ack, e_ack);
        if (e_ack) check("m_ok", ok, e_ok);
        check("m_mode", mode, e_mode);
        check("m_locked", locked, e_lock);
        check("m_super", sup, (priv == 2'd1) || e_mode);

        if (rst_n) begin
            rise = req && !prev_req;
            prev_req = req;
            if (e_mode) begin
                if (exit_p) m_end = cyc + 1;
                else if (rise && (cyc + 1 < m_end)) begin
                    ack_at.push_back(cyc + 1); ack_val.push_back(1'b1);
                end
            end else if (e_lock) begin
                if (rise) begin
                    ack_at.push_back(cyc + 1); ack_val.push_back(1'b0);
                end
            end else if (cyc != chk && rise) begin
                chk = cyc + 1;
                if (key == KEY) begin
                    ack_at.push_back(cyc + 2); ack_val.push_back(1'b1);
                    fails   = 0;
                    m_start = cyc + 2;
                    m_end   = SESS_TO ? cyc + 2 + TOUT : INF;
                end else begin
                    ack_at.push_back(cyc + 2); ack_val.push_back(1'b0);
                    fails++;
                    if (fails == MAXF) begin
                        fails   = 0;
                        l_start = cyc + 2;
                        l_end   = cyc + 2 + LOCK;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic [31:0] k, input logic e);
        @(posedge clk); #1;
        req = r; key = k; exit_p = e;
        @(negedge clk);
        if (ack) ack_cnt++;
        if (locked) lk_cnt++;
        if (mode) md_cnt++;
    endtask

    initial begin
        repeat (3) step(1'b0, '0, 1'b0);
        check("rst_ack", ack, 0);
        check("rst_ok", ok, 0);
        check("rst_mode", mode, 0);
        check("rst_locked", locked, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);

        // Correct key: ack/ok/mode two cycles after the accepting edge.
        step(1'b1, KEY, 1'b0);
        check("acc_ack", ack, 0);
        step(1'b1, KEY, 1'b0);
        check("chk_ack", ack, 0);
        step(1'b1, KEY, 1'b0);
        check("ok_ack", ack, 1);
        check("ok_ok", ok, 1);
        check("ok_mode", mode, 1);
        check("ok_super", sup, 1);

        // Exit together with a new request edge: exit wins, no ack.
        step(1'b0, KEY, 1'b0);
        ack_cnt = 0;
        step(1'b1, KEY, 1'b1);
        step(1'b0, '0, 1'b0);
        check("exit_mode", mode, 0);
        step(1'b0, '0, 1'b0);
        check("exit_noack", ack_cnt, 0);

        // Held request produces exactly one ack.
        ack_cnt = 0;
        repeat (10) step(1'b1, KEY, 1'b0);
        repeat (2) step(1'b0, KEY, 1'b0);
        check("held_acks", ack_cnt, 1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("held_exit", mode, 0);

        // Session length: 8 cycles with the timeout, unbounded without.
        md_cnt = 0;
        repeat (3) step(1'b1, KEY, 1'b0);
        repeat (29) step(1'b0, KEY, 1'b0);
        check("sess_len", md_cnt, SESS_TO ? TOUT : 30);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Three bad keys -> lockout; refused request; lockout length.
        lk_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            step(1'b1, '0, 1'b0);
            step(1'b1, '0, 1'b0);
            step(1'b1, '0, 1'b0);
            check("fail_ack", ack, 1);
            check("fail_ok", ok, 0);
            check("fail_lock", locked, (f == 2));
            step(1'b0, '0, 1'b0);
        end
        step(1'b1, KEY, 1'b0);
        step(1'b1, KEY, 1'b0);
        check("lock_ack", ack, 1);
        check("lock_ok", ok, 0);
        step(1'b0, KEY, 1'b0);
        for (int i = 0; i < 1100 && locked; i++) step(1'b0, '0, 1'b0);
        check("lock_len", lk_cnt, LOCK);
        check("lock_clr", locked, 0);

        // Fail counter was cleared: one bad key does not lock.
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        check("post_ack", ack, 1);
        check("post_ok", ok, 0);
        check("post_locked", locked, 0);
        step(1'b0, '0, 1'b0);

        // Reset during CHECK aborts with no ack.
        step(1'b1, KEY, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk);
        check("rc_ack", ack, 0);
        check("rc_ok", ok, 0);
        check("rc_mode", mode, 0);
        check("rc_locked", locked, 0);
        check("rc_super", sup, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        ack_cnt = 0;
        repeat (5) step(1'b0, KEY, 1'b0);
        check("rc_noack", ack_cnt, 0);

        // Supervisor qualifier from privilege alone.
        @(posedge clk); #1 priv = 2'd1;
        @(negedge clk);
        check("priv_super", sup, 1);
        @(posedge clk); #1 priv = 2'd3;
        @(negedge clk);
        check("priv_mach", sup, 0);
        @(posedge clk); #1 priv = 2'd0;

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 699) != 0);
            if (!rst_n) begin
                req = 1'b0;
            end else if (!req) begin
                if ($urandom_range(0, 3) == 0) begin
                    req = 1'b1;
                    case ($urandom_range(0, 3))
                        0, 1:    key = KEY;
                        2:       key = $urandom;
                        default: key = KEY ^ (32'd1 << $urandom_range(0, 31));
                    endcase
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req = 1'b0;
            end
            exit_p = ($urandom_range(0, 11) == 0);
            priv   = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
